// File: rtl/join_result_packer_if.sv
// join_result_packer_if: sparse input stream, dense output stream and status of the packer
interface join_result_packer_if #(
  parameter int LANES_IN = 8,
  parameter int LANES_OUT = 4,
  parameter int LANE_W = 128
);
  logic [LANES_IN*LANE_W-1:0] in_data;
  logic [LANES_IN*LANE_W/8-1:0] in_keep;
  logic in_valid;
  logic in_last;
  logic in_ready;
  logic [LANES_OUT*LANE_W-1:0] out_data;
  logic [LANES_OUT*LANE_W/8-1:0] out_keep;
  logic out_valid;
  logic out_last;
  logic out_ready;
  logic [31:0] tuple_count;
  logic err_partial;
  modport slave (
    input in_data, in_keep, in_valid, in_last, out_ready,
    output in_ready, out_data, out_keep, out_valid, out_last, tuple_count, err_partial
  );
  modport master (
    output in_data, in_keep, in_valid, in_last, out_ready,
    input in_ready, out_data, out_keep, out_valid, out_last, tuple_count, err_partial
  );
endinterface

// File: rtl/join_result_packer.sv
// join_result_packer: compacts keep-qualified 128-bit lanes into dense output beats,
// preserving order and end-of-stream, counting emitted tuples.
module join_result_packer #(
  parameter int LANES_IN = 8,
  parameter int LANES_OUT = 4,
  parameter int LANE_W = 128,
  parameter int BUF_LANES = 16
) (
  input logic clk,
  input logic rst,
  join_result_packer_if.slave bus
);
  localparam int KW = LANE_W / 8;
  localparam int OW = $clog2(BUF_LANES + 1);
  localparam logic [OW-1:0] LO = OW'(LANES_OUT);
  localparam logic [OW-1:0] HI = OW'(BUF_LANES - LANES_IN);
  logic [BUF_LANES*LANE_W-1:0] buf_q, buf_d;
  logic [OW-1:0] occ_q, occ_d, n, base;
  logic last_q, last_d, err_q, err_d;
  logic [31:0] cnt_q, cnt_d;
  logic [LANES_IN-1:0] lv;
  logic [OW-1:0] pre [LANES_IN+1];
  logic mixed, in_fire, out_fire, in_ready, out_valid, out_last;
  logic [LANES_OUT*KW-1:0] out_keep;
  always_comb begin
    mixed = 1'b0;
    pre[0] = '0;
    for (int i = 0; i < LANES_IN; i++) begin
      lv[i] = &bus.in_keep[i*KW +: KW];
      mixed = mixed | ((|bus.in_keep[i*KW +: KW]) & ~lv[i]);
      pre[i+1] = pre[i] + OW'(lv[i]);
    end
  end
  // slots at or above occ are kept zero, so the low slots can be driven out directly
  always_comb begin
    out_valid = (occ_q >= LO) || last_q;
    out_last = last_q && (occ_q <= LO);
    in_ready = !rst && !last_q && (occ_q <= HI);
    in_fire = bus.in_valid && in_ready;
    out_fire = out_valid && bus.out_ready;
    n = out_fire ? ((occ_q >= LO) ? LO : occ_q) : '0;
    base = occ_q - n;
    buf_d = buf_q >> (LANE_W * int'(n));
    if (in_fire)
      for (int i = 0; i < LANES_IN; i++)
        if (lv[i]) buf_d[(int'(base) + int'(pre[i]))*LANE_W +: LANE_W] = bus.in_data[i*LANE_W +: LANE_W];
    occ_d = base + (in_fire ? pre[LANES_IN] : '0);
    last_d = (in_fire && bus.in_last) ? 1'b1 : (out_fire && out_last) ? 1'b0 : last_q;
    err_d = err_q | (in_fire & mixed);
    cnt_d = cnt_q + 32'(n);
    for (int k = 0; k < LANES_OUT; k++) out_keep[k*KW +: KW] = (occ_q > OW'(k)) ? '1 : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
      occ_q <= '0;
      last_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      occ_q <= occ_d;
      last_q <= last_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.in_ready = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last = out_last;
  assign bus.out_keep = out_keep;
  assign bus.out_data = buf_q[LANES_OUT*LANE_W-1:0];
  assign bus.tuple_count = cnt_q;
  assign bus.err_partial = err_q;
endmodule

// File: tb/tb_join_result_packer.sv
// tb_join_result_packer: per-cycle vector table plus a toggling-backpressure drain sequence.
module tb_join_result_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  join_result_packer_if bus ();
  join_result_packer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    bit rst, vld, lst, ordy;
    logic [7:0] beat, full, mix;
    bit irdy, ov, ol;
    int n;
    logic [15:0] s [4];
    int cnt;
    bit err;
  } vec_t;
  function automatic vec_t v(bit r, bit vl, bit l, bit o, logic [7:0] b, logic [7:0] f, logic [7:0] m,
                             bit ir, bit ov, bit ol, int n, logic [15:0] s0, s1, s2, s3, int c, bit e);
    vec_t x;
    x.rst = r; x.vld = vl; x.lst = l; x.ordy = o; x.beat = b; x.full = f; x.mix = m;
    x.irdy = ir; x.ov = ov; x.ol = ol; x.n = n;
    x.s[0] = s0; x.s[1] = s1; x.s[2] = s2; x.s[3] = s3; x.cnt = c; x.err = e;
    return x;
  endfunction
  function automatic logic [127:0] tup(logic [15:0] tag);
    return {8{tag}};
  endfunction
  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask
  task automatic drive(input vec_t x);
    rst = x.rst;
    bus.in_valid = x.vld;
    bus.in_last = x.lst;
    bus.out_ready = x.ordy;
    for (int l = 0; l < 8; l++) begin
      bus.in_data[l*128 +: 128] = tup({x.beat, 8'(l)});
      bus.in_keep[l*16 +: 16] = x.full[l] ? 16'hFFFF : x.mix[l] ? 16'h00FF : 16'h0000;
    end
  endtask
  vec_t tv [24];
  initial begin
    logic [511:0] ed;
    logic [63:0] ek;
    int got;
    bit done;
    tv[0]  = v(1,0,0,0, 0,0,0,     0,0,0,0, 0,0,0,0, 0,0);
    tv[1]  = v(0,0,0,0, 0,0,0,     1,0,0,0, 0,0,0,0, 0,0);
    tv[2]  = v(0,1,1,1, 1,8'hFF,0, 0,1,0,4, 16'h0100,16'h0101,16'h0102,16'h0103, 0,0);
    tv[3]  = v(0,0,0,1, 0,0,0,     0,1,1,4, 16'h0104,16'h0105,16'h0106,16'h0107, 4,0);
    tv[4]  = v(0,0,0,1, 0,0,0,     1,0,0,0, 0,0,0,0, 8,0);
    tv[5]  = v(0,1,0,1, 2,8'h09,0, 1,0,0,2, 16'h0200,16'h0203,0,0, 8,0);
    tv[6]  = v(0,1,0,1, 3,8'h26,0, 1,1,0,4, 16'h0200,16'h0203,16'h0301,16'h0302, 8,0);
    tv[7]  = v(0,1,1,1, 4,8'h80,0, 0,1,1,2, 16'h0305,16'h0407,0,0, 12,0);
    tv[8]  = v(0,0,0,1, 0,0,0,     1,0,0,0, 0,0,0,0, 14,0);
    tv[9]  = v(0,1,1,1, 5,0,0,     0,1,1,0, 0,0,0,0, 14,0);
    tv[10] = v(0,0,0,1, 0,0,0,     1,0,0,0, 0,0,0,0, 14,0);
    tv[11] = v(0,1,0,0, 6,8'hFF,0, 1,1,0,4, 16'h0600,16'h0601,16'h0602,16'h0603, 14,0);
    tv[12] = v(0,1,0,0, 7,8'hFF,0, 0,1,0,4, 16'h0600,16'h0601,16'h0602,16'h0603, 14,0);
    tv[13] = v(0,1,0,0, 8,8'hFF,0, 0,1,0,4, 16'h0600,16'h0601,16'h0602,16'h0603, 14,0);
    tv[14] = v(0,0,0,1, 0,0,0,     0,1,0,4, 16'h0604,16'h0605,16'h0606,16'h0607, 18,0);
    tv[15] = v(0,0,0,1, 0,0,0,     1,1,0,4, 16'h0700,16'h0701,16'h0702,16'h0703, 22,0);
    tv[16] = v(0,0,0,1, 0,0,0,     1,1,0,4, 16'h0704,16'h0705,16'h0706,16'h0707, 26,0);
    tv[17] = v(0,0,0,1, 0,0,0,     1,0,0,0, 0,0,0,0, 30,0);
    tv[18] = v(0,1,0,0, 9,8'hFB,8'h04, 1,1,0,4, 16'h0900,16'h0901,16'h0903,16'h0904, 30,1);
    tv[19] = v(0,0,0,1, 0,0,0,     1,0,0,3, 16'h0905,16'h0906,16'h0907,0, 34,1);
    tv[20] = v(0,1,1,0, 8'hA,8'h07,0, 0,1,0,4, 16'h0905,16'h0906,16'h0907,16'h0A00, 34,1);
    tv[21] = v(1,0,0,1, 0,0,0,     0,0,0,0, 0,0,0,0, 0,0);
    tv[22] = v(0,0,0,1, 0,0,0,     1,0,0,0, 0,0,0,0, 0,0);
    tv[23] = v(0,0,0,1, 0,0,0,     1,0,0,0, 0,0,0,0, 0,0);
    for (int r = 0; r < 24; r++) begin
      drive(tv[r]);
      @(posedge clk);
      #1;
      ed = '0;
      ek = '0;
      for (int k = 0; k < 4; k++)
        if (k < tv[r].n) begin
          ed[k*128 +: 128] = tup(tv[r].s[k]);
          ek[k*16 +: 16] = 16'hFFFF;
        end
      chk($sformatf("r%0d in_ready", r), 512'(bus.in_ready), 512'(tv[r].irdy));
      chk($sformatf("r%0d out_valid", r), 512'(bus.out_valid), 512'(tv[r].ov));
      chk($sformatf("r%0d out_last", r), 512'(bus.out_last), 512'(tv[r].ol));
      chk($sformatf("r%0d out_keep", r), 512'(bus.out_keep), 512'(ek));
      chk($sformatf("r%0d out_data", r), bus.out_data, ed);
      chk($sformatf("r%0d tuple_count", r), 512'(bus.tuple_count), 512'(tv[r].cnt));
      chk($sformatf("r%0d err_partial", r), 512'(bus.err_partial), 512'(tv[r].err));
    end
    drive(v(0,1,1,0, 8'h0B,8'hFF,0, 0,0,0,0, 0,0,0,0, 0,0));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    got = 0;
    done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      bus.out_ready = c[0];
      if (bus.out_valid && bus.out_ready) begin
        for (int k = 0; k < 4; k++)
          if (bus.out_keep[k*16]) begin
            chk($sformatf("drain t%0d", got), 512'(bus.out_data[k*128 +: 128]), 512'(tup({8'h0B, 8'(got)})));
            got++;
          end
        if (bus.out_last) done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    chk("drain done", 512'(done), 512'(1));
    chk("drain count", 512'(got), 512'(8));
    chk("drain tuple_count", 512'(bus.tuple_count), 512'(8));
    chk("drain out_valid", 512'(bus.out_valid), 512'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
